bomb_defuse_ctrl: RTL
=====================

// Module: bomb_defuse_ctrl
// PURPOSE
//  Upstream controller for the defused-tune piezo stage: runs the bomb countdown, collects keypad
//  digits, checks them against a secret code and asserts 'defused' (drives that stage's bomb input)
//  or 'exploded'. Also exports remaining seconds (BCD) for the 7-segment display block.
// PARAMETERS
//  TICK_CNT   1_000_000  clk cycles per countdown second (sim: 4)
//  SECRET     16'h1234   4-digit BCD defuse code, MS digit first
//  START_SEC  60         initial countdown, integer 1..99
//  PENALTY    10         seconds removed per wrong code
//  MAX_FAIL   3          wrong codes that cause explosion, 1..3
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  arm        in   1   level; starts countdown from IDLE
//  key_valid  in   1   one-cycle strobe, key_data valid
//  key_data   in   4   0-9 digit, 4'hC clear, others ignored
//  armed      out  1   high in ARMED/CHECK
//  defused    out  1   high in DEFUSED (to piezo stage bomb input)
//  exploded   out  1   high in EXPLODED
//  sec_bcd    out  8   remaining seconds, two BCD digits
//  digit_cnt  out  3   digits entered for current attempt, 0..4
//  fail_cnt   out  2   wrong codes so far
// BEHAVIOUR
//  - rst=0: state IDLE, armed/defused/exploded=0, sec_bcd=BCD(START_SEC), digit_cnt=0, fail_cnt=0,
//    entry reg=0, tick counter=0. All outputs registered.
//  - States: IDLE, ARMED, CHECK, DEFUSED, EXPLODED. DEFUSED/EXPLODED terminal until rst.
//  - IDLE: arm=1 at edge -> ARMED; reload sec_bcd, clear tick, entry, digit_cnt, fail_cnt.
//    Keys ignored.
//  - ARMED: key_valid & key_data<=9 -> entry<={entry[11:0],key_data}, digit_cnt+1. key 4'hC -> entry=0,
//    digit_cnt=0. Other codes ignored. Accepting the 4th digit -> CHECK at the same edge.
//  - CHECK (exactly 1 cycle, keys ignored): entry==SECRET -> DEFUSED. Else fail_cnt+1;
//    if fail_cnt+1==MAX_FAIL -> EXPLODED.
//    Else sec -= PENALTY (saturate at 00), entry=0, digit_cnt=0, -> ARMED.
//  - Countdown: in ARMED/CHECK tick counter runs 0..TICK_CNT-1. At terminal count it wraps and sec_bcd
//    decrements as BCD (e.g. 8'h50 -> 8'h49). Frozen in IDLE/DEFUSED/EXPLODED.
//  - sec_bcd reaching 8'h00 (by tick or penalty) -> EXPLODED at that edge.
//  - Simultaneous: tick and penalty on the same edge apply both (-PENALTY-1, saturate 0).
//    Reaching 00 beats a matching code in CHECK and beats a 4th digit in ARMED (-> EXPLODED).
//  - Latency: 4th key sampled at edge k -> CHECK after k; defused/exploded high after edge k+1.
//  - BCD arithmetic only; sec_bcd never holds nibble >9.
//  - rst low mid-operation: immediate async return to reset values. Countdown does not resume.
// TESTING (TICK_CNT=4, defaults otherwise)
//  1. arm, keys 1,2,3,4 -> CHECK, then defused=1 and armed=0 one edge later; sec_bcd frozen thereafter.
//  2. arm, keys 1,2,3,5 -> fail_cnt=1, digit_cnt=0, sec_bcd 8'h60->8'h50 (minus ticks elapsed), back in ARMED.
//  3. three wrong codes -> exploded=1 after third CHECK, fail_cnt=3, defused=0, keys ignored after.
//  4. arm, no keys -> after 60*4 cycles sec_bcd=8'h00 and exploded=1; check 8'h10->8'h09 decrement on the way.
//  5. keys 1,2,C,1,2,3,4; key_data toggling with key_valid=0 -> clear works, stray data ignored, defused=1.
//  6. rst low mid-ARMED (between clk edges) -> outputs at reset values before next edge.
//     arm during DEFUSED has no effect.

Source files
------------

// File: rtl/bomb_defuse_ctrl.sv
// bomb_defuse_ctrl: countdown, keypad code entry and defuse/explode FSM.
// Drives the piezo stage bomb input (defused) and the 7-seg seconds (BCD).
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous, active-low reset
//   arm        level, starts the countdown from IDLE
//   key_valid  one-cycle strobe qualifying key_data
//   key_data   0-9 digit, 4'hC clear, other codes ignored
//   armed      high while counting down (ARMED/CHECK)
//   defused    high once the correct code was entered
//   exploded   high once time ran out or too many wrong codes
//   sec_bcd    remaining seconds, two BCD digits
//   digit_cnt  digits entered for the current attempt
//   fail_cnt   wrong codes so far
module bomb_defuse_ctrl #(
  parameter int          TICK_CNT  = 1_000_000,
  parameter logic [15:0] SECRET    = 16'h1234,
  parameter int          START_SEC = 60,
  parameter int          PENALTY   = 10,
  parameter int          MAX_FAIL  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       key_valid,
  input  logic [3:0] key_data,
  output logic       armed,
  output logic       defused,
  output logic       exploded,
  output logic [7:0] sec_bcd,
  output logic [2:0] digit_cnt,
  output logic [1:0] fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CHECK,
    S_DEFUSED,
    S_EXPLODED
  } state_t;

  localparam int TW =
    (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICK_CNT - 1);
  localparam logic [7:0] START_BCD =
    {4'(START_SEC / 10), 4'(START_SEC % 10)};
  localparam logic [6:0] PEN = 7'(PENALTY);
  localparam logic [1:0] FAIL_LIM = 2'(MAX_FAIL);

  state_t          state, state_n;
  logic [TW-1:0]   tick, tick_n;
  logic [15:0]     entry, entry_n;
  logic [7:0]      sec_n;
  logic [2:0]      dcnt_n;
  logic [1:0]      fcnt_n;
  logic [1:0]      fcnt_inc;
  logic            run;
  logic            tc;
  logic            key_dig;
  logic            key_clr;
  logic [6:0]      dec;

  // Saturating BCD subtract of a small binary amount.
  // Goes through binary so the result is always
  // a legal two-digit BCD value.
  function automatic logic [7:0] bcd_sub(
    input logic [7:0] v,
    input logic [6:0] d
  );
    logic [7:0] bin;
    logic [7:0] r;
    logic [7:0] t;
    logic [7:0] o;
    bin = 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
    if (bin <= {1'b0, d}) return 8'h00;
    r = bin - {1'b0, d};
    t = r / 8'd10;
    o = r % 8'd10;
    return {t[3:0], o[3:0]};
  endfunction

  always_comb begin
    state_n  = state;
    sec_n    = sec_bcd;
    tick_n   = tick;
    entry_n  = entry;
    dcnt_n   = digit_cnt;
    fcnt_n   = fail_cnt;
    run      = (state == S_ARMED) ||
               (state == S_CHECK);
    tc       = run && (tick == TICK_LAST);
    key_dig  = key_valid && (key_data <= 4'd9);
    key_clr  = key_valid && (key_data == 4'hC);
    fcnt_inc = fail_cnt + 2'd1;
    dec      = {6'd0, tc};

    if (run) begin
      tick_n = tc ? '0 : tick + TW'(1);
    end

    unique case (state)
      S_IDLE: begin
        if (arm) begin
          state_n = S_ARMED;
          sec_n   = START_BCD;
          tick_n  = '0;
          entry_n = '0;
          dcnt_n  = '0;
          fcnt_n  = '0;
        end
      end

      S_ARMED: begin
        unique case (1'b1)
          key_dig: begin
            entry_n = {entry[11:0], key_data};
            dcnt_n  = digit_cnt + 3'd1;
          end
          key_clr: begin
            entry_n = '0;
            dcnt_n  = '0;
          end
          default: ;
        endcase
        sec_n = bcd_sub(sec_bcd, dec);
        // Running out of time wins over a 4th digit.
        if (sec_n == 8'h00) begin
          state_n = S_EXPLODED;
        end else if (key_dig &&
                     digit_cnt == 3'd3) begin
          state_n = S_CHECK;
        end
      end

      S_CHECK: begin
        if (entry == SECRET) begin
          sec_n   = bcd_sub(sec_bcd, dec);
          state_n = (sec_n == 8'h00) ?
                    S_EXPLODED : S_DEFUSED;
        end else begin
          fcnt_n = fcnt_inc;
          if (fcnt_inc == FAIL_LIM) begin
            sec_n   = bcd_sub(sec_bcd, dec);
            state_n = S_EXPLODED;
          end else begin
            // Tick and penalty may land together.
            sec_n   = bcd_sub(sec_bcd, dec + PEN);
            entry_n = '0;
            dcnt_n  = '0;
            state_n = (sec_n == 8'h00) ?
                      S_EXPLODED : S_ARMED;
          end
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      sec_bcd   <= START_BCD;
      tick      <= '0;
      entry     <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      armed     <= 1'b0;
      defused   <= 1'b0;
      exploded  <= 1'b0;
    end else begin
      state     <= state_n;
      sec_bcd   <= sec_n;
      tick      <= tick_n;
      entry     <= entry_n;
      digit_cnt <= dcnt_n;
      fail_cnt  <= fcnt_n;
      armed     <= (state_n == S_ARMED) ||
                   (state_n == S_CHECK);
      defused   <= (state_n == S_DEFUSED);
      exploded  <= (state_n == S_EXPLODED);
    end
  end

endmodule
